// File: rtl/retospect_nn_pkg.sv
// Shared constants, cell state type and configuration-chain helpers for the LIF neuron cell.
// Chain layout depends on whether RETOSPECT_LIF_INHIBIT_EN is defined (adds one sign bit per dendrite).
package retospect_nn_pkg;

    localparam int DEF_N_DEND      = 4;
    localparam int DEF_W_BITS      = 3;
    localparam int DEF_POT_BITS    = 6;
    localparam int DEF_REFRAC_BITS = 3;
    localparam int DEF_N_DECAY     = 8;

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } cell_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    function automatic int sign_bits(input int n_dend);
`ifdef RETOSPECT_LIF_INHIBIT_EN
        return n_dend;
`else
        return 0;
`endif
    endfunction

    function automatic int chain_len(input int n_dend, input int w_bits, input int pot_bits,
                                     input int n_decay, input int refrac_bits);
        return n_dend * w_bits + sign_bits(n_dend) + pot_bits + clog2(n_decay) + refrac_bits;
    endfunction

endpackage

// File: rtl/retospect_cfg_chain.sv
// Generic serial configuration shift register with parallel read-out.
// Bits enter at the MSB end and leave at bit 0, so bs_out is always a registered value.
module retospect_cfg_chain #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             config_en,
    input  logic             bs_in,
    output logic             bs_out,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (reset) begin
            data <= '0;
        end else if (config_en) begin
            data <= {bs_in, data[WIDTH-1:1]};
        end
    end

    assign bs_out = data[0];

endmodule

// File: rtl/retospect_lif_cell.sv
// Leaky integrate-and-fire neuron cell with serially loaded per-cell configuration.
// Define RETOSPECT_LIF_INHIBIT_EN to add per-dendrite sign bits (inhibitory dendrites).
module retospect_lif_cell
    import retospect_nn_pkg::*;
#(
    parameter int N_DEND      = DEF_N_DEND,
    parameter int W_BITS      = DEF_W_BITS,
    parameter int POT_BITS    = DEF_POT_BITS,
    parameter int REFRAC_BITS = DEF_REFRAC_BITS,
    parameter int N_DECAY     = DEF_N_DECAY
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_nn,
    input  logic                    config_en,
    input  logic                    bs_in,
    output logic                    bs_out,
    input  logic [N_DECAY-1:0]      decay_bus,
    input  logic [N_DEND-1:0]       dendrite,
    output logic                    axon,
    output cell_state_t             dbg_state,
    output logic [POT_BITS-1:0]     dbg_potential,
    output logic [REFRAC_BITS-1:0]  dbg_refrac_cnt,
    output logic [chain_len(N_DEND, W_BITS, POT_BITS, N_DECAY, REFRAC_BITS)-1:0] dbg_cfg
);

    localparam int DSEL_BITS = clog2(N_DECAY);
    localparam int CHAIN_L   = chain_len(N_DEND, W_BITS, POT_BITS, N_DECAY, REFRAC_BITS);
    localparam int SUM_W     = POT_BITS + clog2(N_DEND) + 2;

    // Field offsets, counted from the bs_out end of the chain.
    localparam int REF_LO  = 0;
    localparam int DSEL_LO = REF_LO + REFRAC_BITS;
    localparam int THR_LO  = DSEL_LO + DSEL_BITS;
    localparam int SIGN_LO = THR_LO + POT_BITS;
    localparam int WT_LO   = SIGN_LO + sign_bits(N_DEND);

    logic [CHAIN_L-1:0]     cfg;
    logic [W_BITS-1:0]      weight [N_DEND];
    logic [POT_BITS-1:0]    threshold;
    logic [DSEL_BITS-1:0]   dsel;
    logic [REFRAC_BITS-1:0] refrac_len;

    logic [POT_BITS-1:0]    potential;
    logic [REFRAC_BITS-1:0] refrac_cnt;

    logic [POT_BITS-1:0]    leaked;
    logic [SUM_W-1:0]       dend_sum;
    logic [SUM_W-1:0]       total;
    logic [POT_BITS-1:0]    sat_pot;
    logic                   fire;

    // reset_nn outranks config_en, so it also blocks chain shifting.
    retospect_cfg_chain #(
        .WIDTH (CHAIN_L)
    ) u_chain (
        .clk       (clk),
        .reset     (reset),
        .config_en (config_en & ~reset_nn),
        .bs_in     (bs_in),
        .bs_out    (bs_out),
        .data      (cfg)
    );

`ifdef RETOSPECT_LIF_INHIBIT_EN
    logic [N_DEND-1:0] inhibit;
`endif

    for (genvar gi = 0; gi < N_DEND; gi++) begin : g_field
        assign weight[gi] = cfg[WT_LO + (N_DEND - 1 - gi) * W_BITS +: W_BITS];
`ifdef RETOSPECT_LIF_INHIBIT_EN
        assign inhibit[gi] = cfg[SIGN_LO + N_DEND - 1 - gi];
`endif
    end

    assign threshold  = cfg[THR_LO +: POT_BITS];
    assign dsel       = cfg[DSEL_LO +: DSEL_BITS];
    assign refrac_len = cfg[REF_LO +: REFRAC_BITS];

    // Leak first, then the two's-complement dendrite sum, then clamp.
    always_comb begin
        leaked   = decay_bus[dsel] ? (potential >> 1) : potential;
        dend_sum = '0;
        for (int i = 0; i < N_DEND; i++) begin
            if (dendrite[i]) begin
`ifdef RETOSPECT_LIF_INHIBIT_EN
                if (inhibit[i]) begin
                    dend_sum = dend_sum - SUM_W'(weight[i]);
                end else begin
                    dend_sum = dend_sum + SUM_W'(weight[i]);
                end
`else
                dend_sum = dend_sum + SUM_W'(weight[i]);
`endif
            end
        end
        total = SUM_W'(leaked) + dend_sum;
`ifdef RETOSPECT_LIF_INHIBIT_EN
        if (total[SUM_W-1]) begin
            sat_pot = '0;
        end else if (|total[SUM_W-2:POT_BITS]) begin
            sat_pot = '1;
        end else begin
            sat_pot = total[POT_BITS-1:0];
        end
`else
        if (|total[SUM_W-1:POT_BITS]) begin
            sat_pot = '1;
        end else begin
            sat_pot = total[POT_BITS-1:0];
        end
`endif
        fire = (threshold != '0) && (sat_pot >= threshold);
    end

    always_ff @(posedge clk) begin
        if (reset || reset_nn) begin
            potential  <= '0;
            refrac_cnt <= '0;
            axon       <= 1'b0;
        end else if (config_en) begin
            axon <= 1'b0;
        end else if (refrac_cnt != '0) begin
            potential  <= '0;
            refrac_cnt <= refrac_cnt - REFRAC_BITS'(1);
            axon       <= 1'b0;
        end else if (fire) begin
            potential  <= '0;
            refrac_cnt <= refrac_len;
            axon       <= 1'b1;
        end else begin
            potential <= sat_pot;
            axon      <= 1'b0;
        end
    end

    assign dbg_state      = (refrac_cnt != '0) ? REFRACTORY : INTEGRATE;
    assign dbg_potential  = potential;
    assign dbg_refrac_cnt = refrac_cnt;
    assign dbg_cfg        = cfg;

endmodule

// File: tb/tb_retospect_lif_cell.sv
// Randomised and directed bench for retospect_lif_cell against an integer-level neuron model.
module tb_retospect_lif_cell;
    import retospect_nn_pkg::*;

    localparam int L     = chain_len(4, 3, 6, 8, 3);
    localparam int SGN_N = sign_bits(4);
    localparam int WT_LO = 3 + 3 + 6 + SGN_N;
`ifdef RETOSPECT_LIF_INHIBIT_EN
    localparam int INH_EXP = 0;
`else
    localparam int INH_EXP = 11;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         reset_nn = 1'b0;
    logic         config_en = 1'b0;
    logic         bs_in = 1'b0;
    logic         bs_out;
    logic [7:0]   decay_bus = '0;
    logic [3:0]   dendrite = '0;
    logic         axon;
    cell_state_t  dbg_state;
    logic [5:0]   dbg_potential;
    logic [2:0]   dbg_refrac_cnt;
    logic [L-1:0] dbg_cfg;

    retospect_lif_cell dut (
        .clk            (clk),
        .reset          (reset),
        .reset_nn       (reset_nn),
        .config_en      (config_en),
        .bs_in          (bs_in),
        .bs_out         (bs_out),
        .decay_bus      (decay_bus),
        .dendrite       (dendrite),
        .axon           (axon),
        .dbg_state      (dbg_state),
        .dbg_potential  (dbg_potential),
        .dbg_refrac_cnt (dbg_refrac_cnt),
        .dbg_cfg        (dbg_cfg)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int n_pulse = 0;

    // Reference model state: raw chain contents plus neuron variables as integers.
    logic [L-1:0] m_cfg = '0;
    int  m_pot = 0;
    int  m_cnt = 0;
    bit  m_axon = 1'b0;
    logic [6:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int f_weight(input int i);
        return int'(m_cfg >> (WT_LO + (3 - i) * 3)) & 7;
    endfunction
    function automatic int f_sign(input int i);
        if (SGN_N == 0) return 0;
        return int'(m_cfg >> (12 + 3 - i)) & 1;
    endfunction
    function automatic int f_thr();
        return int'(m_cfg >> 6) & 63;
    endfunction
    function automatic int f_dsel();
        return int'(m_cfg >> 3) & 7;
    endfunction
    function automatic int f_rl();
        return int'(m_cfg) & 7;
    endfunction

    task automatic model_step(input bit rst, input bit rnn, input bit cen, input bit bi,
                              input logic [7:0] dec, input logic [3:0] den);
        int p, s, n;
        if (rst) begin
            m_cfg = '0; m_pot = 0; m_cnt = 0; m_axon = 0;
        end else if (rnn) begin
            m_pot = 0; m_cnt = 0; m_axon = 0;
        end else if (cen) begin
            m_cfg = {bi, m_cfg[L-1:1]};
            m_axon = 0;
        end else if (m_cnt > 0) begin
            m_cnt--; m_pot = 0; m_axon = 0;
        end else begin
            p = dec[f_dsel()] ? m_pot / 2 : m_pot;
            s = 0;
            for (int i = 0; i < 4; i++) begin
                if (den[i]) s += (f_sign(i) != 0) ? -f_weight(i) : f_weight(i);
            end
            n = p + s;
            if (n < 0) n = 0;
            if (n > 63) n = 63;
            if (f_thr() != 0 && n >= f_thr()) begin
                m_axon = 1; m_pot = 0; m_cnt = f_rl();
            end else begin
                m_axon = 0; m_pot = n;
            end
        end
    endtask

    task automatic tick(input bit rst, input bit rnn, input bit cen, input bit bi,
                        input logic [7:0] dec, input logic [3:0] den);
        logic [6:0] e;
        reset = rst; reset_nn = rnn; config_en = cen; bs_in = bi;
        decay_bus = dec; dendrite = den;
        @(posedge clk);
        model_step(rst, rnn, cen, bi, dec, den);
        exp_q.push_back({m_axon, 6'(m_pot)});
        #1;
        e = exp_q.pop_front();
        check("axon", 32'(axon), 32'(e[6]));
        check("potential", 32'(dbg_potential), 32'(e[5:0]));
        check("refrac_cnt", 32'(dbg_refrac_cnt), 32'(m_cnt));
        check("state", 32'(dbg_state), 32'(m_cnt != 0));
        check("bs_out", 32'(bs_out), 32'(m_cfg[0]));
        if (axon) n_pulse++;
    endtask

    task automatic run(input int cycles, input logic [7:0] dec, input logic [3:0] den);
        for (int k = 0; k < cycles; k++) tick(0, 0, 0, 0, dec, den);
    endtask

    task automatic load_cfg(input int w0, input int w1, input int w2, input int w3,
                            input logic [3:0] s_mask, input int thr, input int dsel,
                            input int rl);
        logic [L-1:0] v;
        int w[4];
        int pos;
        w = '{w0, w1, w2, w3};
        v = '0;
        pos = L;
        for (int i = 0; i < 4; i++) begin
            pos -= 3;
            v[pos +: 3] = 3'(w[i]);
        end
        for (int i = 0; i < SGN_N; i++) begin
            pos -= 1;
            v[pos] = s_mask[i];
        end
        pos -= 6; v[pos +: 6] = 6'(thr);
        pos -= 3; v[pos +: 3] = 3'(dsel);
        pos -= 3; v[pos +: 3] = 3'(rl);
        for (int k = 0; k < L; k++) tick(0, 0, 1, v[k], 8'h00, 4'h0);
        check("bs_first", 32'(bs_out), 32'(v[0]));
        check("cfg_vec", 32'(dbg_cfg), 32'(v));
    endtask

    initial begin
        logic [L-1:0] saved;
        int r;

        tick(1, 0, 0, 0, 8'h00, 4'h0);
        tick(1, 0, 0, 0, 8'hff, 4'hf);
        check("reset_cfg", 32'(dbg_cfg), 32'd0);

        // Test-plan configuration image.
        load_cfg(3, 1, 2, 7, 4'b1000, 8, 1, 2);

        // Integrate to threshold, then periodic firing with refractory 2.
        load_cfg(3, 1, 2, 7, 4'b1000, 8, 0, 2);
        tick(0, 0, 0, 0, 8'h00, 4'h1);
        check("pot_step1", 32'(dbg_potential), 32'd3);
        tick(0, 0, 0, 0, 8'h00, 4'h1);
        check("pot_step2", 32'(dbg_potential), 32'd6);
        tick(0, 0, 0, 0, 8'h00, 4'h1);
        check("fire_axon", 32'(axon), 32'd1);
        check("fire_pot", 32'(dbg_potential), 32'd0);
        n_pulse = 0;
        run(25, 8'h00, 4'h1);
        check("pulse_cnt", 32'(n_pulse), 32'd5);

        // reset_nn mid-refractory clears the counter but keeps config.
        run(5, 8'h00, 4'h0);
        saved = dbg_cfg;
        run(3, 8'h00, 4'h1);
        tick(0, 1, 0, 0, 8'h00, 4'h1);
        check("rnn_cnt", 32'(dbg_refrac_cnt), 32'd0);
        check("rnn_cfg", 32'(dbg_cfg), 32'(saved));
        tick(0, 0, 0, 0, 8'h00, 4'h1);
        check("rnn_integrate", 32'(dbg_potential), 32'd3);

        // config_en mid-refractory freezes the counter.
        run(2, 8'h00, 4'h1);
        tick(0, 0, 1, m_cfg[L-1], 8'h00, 4'h0);
        check("cen_freeze", 32'(dbg_refrac_cnt), 32'd2);
        run(4, 8'h00, 4'h0);

        // Leak on decay line 1.
        load_cfg(5, 3, 0, 0, 4'b0000, 0, 1, 0);
        tick(0, 1, 0, 0, 8'h00, 4'h0);
        run(4, 8'h00, 4'h1);
        check("leak_start", 32'(dbg_potential), 32'd20);
        tick(0, 0, 0, 0, 8'h02, 4'h0); check("leak_10", 32'(dbg_potential), 32'd10);
        tick(0, 0, 0, 0, 8'h02, 4'h0); check("leak_5", 32'(dbg_potential), 32'd5);
        tick(0, 0, 0, 0, 8'h02, 4'h0); check("leak_2", 32'(dbg_potential), 32'd2);
        tick(0, 0, 0, 0, 8'h02, 4'h0); check("leak_1", 32'(dbg_potential), 32'd1);
        tick(0, 0, 0, 0, 8'h02, 4'h0); check("leak_0", 32'(dbg_potential), 32'd0);
        run(4, 8'hfd, 4'h1);
        tick(0, 0, 0, 0, 8'h02, 4'h2);
        check("leak_then_sum", 32'(dbg_potential), 32'd13);

        // Inhibition floor and upper saturation.
        load_cfg(6, 4, 7, 7, 4'b1000, 0, 0, 0);
        tick(0, 1, 0, 0, 8'h00, 4'h0);
        tick(0, 0, 0, 0, 8'h00, 4'h2);
        check("inh_pre", 32'(dbg_potential), 32'd4);
        tick(0, 0, 0, 0, 8'h00, 4'h8);
        check("inh_floor", 32'(dbg_potential), 32'(INH_EXP));
        tick(0, 1, 0, 0, 8'h00, 4'h0);
        run(10, 8'h00, 4'h1);
        check("sat_pre", 32'(dbg_potential), 32'd60);
        tick(0, 0, 0, 0, 8'h00, 4'h4);
        check("sat_top", 32'(dbg_potential), 32'd63);

        // Random traffic with occasional network resets, partial shifts and reloads.
        for (int it = 0; it < 600; it++) begin
            if (it % 150 == 0) begin
                load_cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                         $urandom_range(0, 7), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 30), $urandom_range(0, 7), $urandom_range(0, 4));
            end
            r = $urandom_range(0, 99);
            if (r < 3) tick(0, 1, 0, 0, 8'($urandom), 4'($urandom));
            else if (r < 8) tick(0, 0, 1, 1'($urandom), 8'($urandom), 4'($urandom));
            else tick(0, 0, 0, 0, 8'($urandom), 4'($urandom));
        end

        tick(1, 0, 0, 0, 8'hff, 4'hf);
        check("final_cfg", 32'(dbg_cfg), 32'd0);
        check("final_axon", 32'(axon), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/retospect_lif_cell.md
# retospect_lif_cell

Parametrised leaky integrate-and-fire neuron cell for the neurochip array, successor to the fixed 4-dendrite/3-bit cell. It integrates weighted dendrite spikes into a saturating membrane potential, decays it from a selectable decay-bus line, and fires at a configurable threshold followed by a configurable refractory period. All per-cell settings come from a serial bitstream chain, so cells daisy-chain exactly as in the array's configuration path.

## Interface
Parameters:
- N_DEND, 4, number of dendrite inputs
- W_BITS, 3, weight magnitude width per dendrite
- POT_BITS, 6, membrane potential and threshold width
- REFRAC_BITS, 3, refractory length width
- N_DECAY, 8, decay bus width (power of two, ≥2); DSEL_BITS = clog2(N_DECAY)

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clears all state and config
- reset_nn  in  1  network reset: clears potential/refractory, keeps config
- config_en  in  1  shift configuration chain one bit per cycle
- bs_in  in  1  configuration serial input
- bs_out  out  1  configuration serial output (last chain bit)
- decay_bus  in  N_DECAY  decay strobes from the clock box
- dendrite  in  N_DEND  incoming spikes, sampled each cycle
- axon  out  1  registered spike output, one-cycle pulse

## Operation
- Priority per cycle: reset > reset_nn > config_en > run.
- reset: weights, signs, threshold, decay select, refractory length, potential, refractory counter, axon all 0.
- reset_nn: potential 0, refractory counter 0, axon 0; config untouched.
- config_en: chain shifts toward bs_out; order from bs_in: weight[0..N_DEND-1] (W_BITS each), sign[0..N_DEND-1] (macro only), threshold (POT_BITS), decay select (DSEL_BITS), refractory length (REFRAC_BITS). Each field shifts in MSB-first toward its LSB end; bs_out = LSB of refractory length field. Potential, counter frozen; axon 0.
- Run, state INTEGRATE (refractory counter = 0):
  - leak: if decay_bus[dsel] then p' = p >> 1 else p' = p.
  - sum: S = Σ over active dendrites of +weight (or −weight if sign set); evaluated in signed width POT_BITS+clog2(N_DEND)+2.
  - n = p' + S, saturated to [0, 2^POT_BITS−1].
  - if n ≥ threshold and threshold ≠ 0: axon ← 1, potential ← 0, counter ← refractory length.
  - threshold = 0: cell never fires (disabled); potential still integrates.
  - else axon ← 0, potential ← n.
- Run, state REFRACTORY (counter ≠ 0): dendrites ignored, no leak, potential held at 0, counter decrements, axon 0.
- Refractory length 0: cell may fire on consecutive cycles.

## Timing
- Dendrite sampled at edge t; resulting axon pulse visible after edge t (1-cycle latency), high for exactly one cycle.
- After firing at edge t with refractory length R: dendrites at edges t+1..t+R ignored; integration resumes at edge t+R+1.
- Simultaneous decay and spikes: leak applied first, then sum.
- config_en mid-refractory: counter frozen, resumes on deassert. reset_nn or reset mid-refractory: counter cleared immediately.
- bs_out registered; chain latency equals chain length L (default 28 with macro, 24 without).

## Configuration
- RETOSPECT_LIF_INHIBIT_EN defined: N_DEND sign bits present in chain; sign=1 makes that dendrite inhibitory (subtract).
- Undefined: no sign bits in chain, all dendrites excitatory, sum unsigned, only upper saturation applies; chain length shrinks by N_DEND.

## Structure
- Package retospect_nn_pkg: clog2 helper, default parameter constants, cell state enum (INTEGRATE, REFRACTORY), chain-length function of parameters and macro.
- Sub-module retospect_cfg_chain: generic parametrised serial shift register with parallel read-out, hold on !config_en, clear on reset; cell slices fields from it.
- Refractory state derived from counter ≠ 0; no separate state register.

## Test plan
- Config load: shift 28-bit pattern, weights 3,1,2,7, signs 0001, threshold 8, dsel 1, refrac 2 → parallel fields match; bs_out reproduces first bit after 28 cycles.
- Integrate/fire: weight[0]=3, threshold 8, dsel 0, dendrite[0] high 3 cycles → potential 3,6 then axon pulse on third edge, potential 0.
- Refractory: refrac 2, dendrite[0] held high → axon pulses every 5th cycle (3 integrate + 2 refractory), never two adjacent.
- Leak: potential 20, dsel 1, no spikes → 10,5,2,1,0 on successive edges; with dendrite weight 3 simultaneously → 13.
- Inhibition/saturation: dendrite[3] weight 7 inhibitory on potential 4 → 0; weight 7 excitatory from 60 → 63.
- Resets: reset_nn mid-refractory → counter 0, config kept, next spike integrates; reset → all fields 0, axon 0.
